// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: button-driven LED pattern mode controller.
// Two raw push-buttons are synchronized and debounced. btn_next steps the
// pattern mode (shift -> count -> Johnson -> shift). btn_pause freezes and
// resumes the step divider that paces the downstream pattern stage.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   btn_next     raw push-button, advances mode
//   btn_pause    raw push-button, toggles pause
//   mode[1:0]    pattern select: 00 shift, 01 count, 10 Johnson
//   step_tick    one-cycle pattern advance enable
//   mode_changed one-cycle pulse in the first cycle of a new mode
//   paused       high while stepping is frozen
module led_mode_ctrl #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned STEP_DIV  = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_pause,
    output logic [1:0] mode,
    output logic       step_tick,
    output logic       mode_changed,
    output logic       paused
);

    localparam int unsigned NBTN  = 2;
    localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        M_SHIFT   = 2'b00,
        M_COUNT   = 2'b01,
        M_JOHNSON = 2'b10
    } mode_t;

    // Bit 0 is btn_next, bit 1 is btn_pause.
    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] db_lvl;
    logic [NBTN-1:0] db_lvl_q;
    logic [NBTN-1:0] press;
    logic [DB_W-1:0] db_cnt [NBTN];

    mode_t            state;
    logic [DIV_W-1:0] div_cnt;
    logic             adv;
    logic             paused_n;

    assign raw = {btn_pause, btn_next};

    // Synchronizer, per-button debounce and registered rising-edge press event.
    // The level only flips after DB_CYCLES consecutive disagreeing cycles;
    // any agreeing cycle restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            db_lvl   <= '0;
            db_lvl_q <= '0;
            press    <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            db_lvl_q <= db_lvl;
            press    <= db_lvl & ~db_lvl_q;
            for (int i = 0; i < NBTN; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign adv      = press[0];
    assign paused_n = paused ^ press[1];

    // Mode FSM and step divider. The divider freezes from the edge that
    // enters pause, so a tick is never emitted in a paused cycle; a mode
    // advance restarts the divider and suppresses a coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= M_SHIFT;
            mode_changed <= 1'b0;
            paused       <= 1'b0;
            step_tick    <= 1'b0;
            div_cnt      <= '0;
        end else begin
            mode_changed <= adv;
            paused       <= paused_n;

            case (state)
                M_SHIFT:   if (adv) state <= M_COUNT;
                M_COUNT:   if (adv) state <= M_JOHNSON;
                M_JOHNSON: if (adv) state <= M_SHIFT;
                default:   state <= M_SHIFT;
            endcase

            if (adv) begin
                div_cnt   <= '0;
                step_tick <= 1'b0;
            end else if (!paused_n) begin
                step_tick <= (div_cnt == DIV_LAST);
                div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            end else begin
                step_tick <= 1'b0;
            end
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Testbench for led_mode_ctrl with DB_CYCLES=4, STEP_DIV=5.
// Table vectors hold button levels for a window of cycles and check the
// final mode/paused plus tick count and first/last tick cycle in the window.
// Expected mode_changed pulses are queued when a qualifying press is driven
// and matched cycle-by-cycle as the DUT runs.
module tb_led_mode_ctrl;

    localparam int unsigned DB   = 4;
    localparam int unsigned STEP = 5;
    // First sampling edge to first cycle of new mode: 2 sync + DB + 1.
    localparam int LAT = 2 + DB + 1;

    logic       clk;
    logic       reset;
    logic       btn_next;
    logic       btn_pause;
    logic [1:0] mode;
    logic       step_tick;
    logic       mode_changed;
    logic       paused;

    led_mode_ctrl #(
        .DB_CYCLES(DB),
        .STEP_DIV (STEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_next    (btn_next),
        .btn_pause   (btn_pause),
        .mode        (mode),
        .step_tick   (step_tick),
        .mode_changed(mode_changed),
        .paused      (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       nxt;
        logic       pau;
        int         cycles;
        logic [1:0] exp_mode;
        logic       exp_paused;
        int         ticks;   // -1: tick statistics not checked
        int         first;
        int         last;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
    } mc_t;

    mc_t        sb[$];
    vec_t       tbl[19];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    int         w_ticks, w_first, w_last;
    logic       prev_nxt;
    logic [1:0] sb_mode;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: advance, then sample on the falling edge.
    task automatic cycle();
        bit  exp_mc;
        mc_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        exp_mc = (sb.size() > 0) && (sb[0].cyc <= cyc);
        chk("mode_changed", int'(mode_changed), int'(exp_mc));
        if (exp_mc) begin
            e = sb.pop_front();
            chk("new_mode", int'(mode), int'(e.mode));
        end
        chk("mode_legal", int'(mode == 2'b11), 0);
        if (step_tick) begin
            w_ticks++;
            if (w_first < 0) w_first = cyc;
            w_last = cyc;
        end
    endtask

    task automatic apply_vec(input vec_t v);
        mc_t e;
        if (v.nxt && !prev_nxt && v.cycles >= int'(DB)) begin
            sb_mode = (sb_mode == 2'd2) ? 2'd0 : sb_mode + 2'd1;
            e.cyc   = cyc + 1 + LAT;
            e.mode  = sb_mode;
            sb.push_back(e);
        end
        prev_nxt  = v.nxt;
        btn_next  = v.nxt;
        btn_pause = v.pau;
        w_ticks   = 0;
        w_first   = -1;
        w_last    = -1;
        repeat (v.cycles) cycle();
        chk("mode", int'(mode), int'(v.exp_mode));
        chk("paused", int'(paused), int'(v.exp_paused));
        if (v.ticks >= 0) begin
            chk("tick_count", w_ticks, v.ticks);
            chk("first_tick", w_first, v.first);
            chk("last_tick", w_last, v.last);
        end
    endtask

    initial begin
        //            nxt   pau   cyc mode   p     n   first last
        tbl[0]  = '{1'b0, 1'b0, 30, 2'd0, 1'b0, 6,   5,   30};  // idle ticks every 5
        tbl[1]  = '{1'b1, 1'b0,  3, 2'd0, 1'b0, 0,  -1,   -1};  // short glitch
        tbl[2]  = '{1'b0, 1'b0, 12, 2'd0, 1'b0, 3,  35,   45};
        tbl[3]  = '{1'b1, 1'b0, 40, 2'd1, 1'b0, 7,  50,   83};  // held: one advance, divider restart
        tbl[4]  = '{1'b0, 1'b0, 10, 2'd1, 1'b0, 2,  88,   93};
        tbl[5]  = '{1'b1, 1'b0,  6, 2'd1, 1'b0, 1,  98,   98};
        tbl[6]  = '{1'b0, 1'b0, 10, 2'd2, 1'b0, 1, 108,  108};  // advance eats coincident tick
        tbl[7]  = '{1'b1, 1'b0,  6, 2'd2, 1'b0, 1, 113,  113};
        tbl[8]  = '{1'b0, 1'b0, 12, 2'd0, 1'b0, 3, 118,  129};  // wrap 10 -> 00
        tbl[9]  = '{1'b0, 1'b1,  6, 2'd0, 1'b0, 1, 134,  134};
        tbl[10] = '{1'b0, 1'b0, 20, 2'd0, 1'b1, 0,  -1,   -1};  // paused: no ticks
        tbl[11] = '{1'b0, 1'b1,  6, 2'd0, 1'b1, 0,  -1,   -1};
        tbl[12] = '{1'b0, 1'b0, 12, 2'd0, 1'b0, 2, 165,  170};  // resume from held count
        tbl[13] = '{1'b1, 1'b0,  6, 2'd0, 1'b0, -1,  0,    0};
        tbl[14] = '{1'b0, 1'b0, 10, 2'd1, 1'b0, -1,  0,    0};
        tbl[15] = '{1'b1, 1'b0,  6, 2'd1, 1'b0, -1,  0,    0};
        tbl[16] = '{1'b0, 1'b0, 10, 2'd2, 1'b0, -1,  0,    0};
        tbl[17] = '{1'b0, 1'b1,  6, 2'd2, 1'b0, -1,  0,    0};
        tbl[18] = '{1'b0, 1'b0, 10, 2'd2, 1'b1, -1,  0,    0};  // mode 10, paused

        btn_next  = 1'b0;
        btn_pause = 1'b0;
        prev_nxt  = 1'b0;
        sb_mode   = 2'd0;
        reset     = 1'b0;
        #1 reset  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mode", int'(mode), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_tick", int'(step_tick), 0);
        chk("rst_mc", int'(mode_changed), 0);
        reset = 1'b0;
        cyc   = 0;

        for (int i = 0; i < 19; i++) begin
            apply_vec(tbl[i]);
        end

        // Asynchronous reset mid-cycle while in mode 10 and paused.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_mode", int'(mode), 0);
        chk("async_paused", int'(paused), 0);
        chk("async_tick", int'(step_tick), 0);
        chk("async_mc", int'(mode_changed), 0);
        sb.delete();
        sb_mode  = 2'd0;
        prev_nxt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        apply_vec('{1'b0, 1'b0, 10, 2'd0, 1'b0, 2, 5, 10});

        // Coincident next and pause presses act together.
        apply_vec('{1'b1, 1'b1, 6, 2'd0, 1'b0, -1, 0, 0});
        apply_vec('{1'b0, 1'b0, 10, 2'd1, 1'b1, -1, 0, 0});

        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 SHALL provide parameter DB_CYCLES, default 500000, consecutive stable cycles required to accept a debounced button level (10 ms at 50 MHz).
REQ-002 SHALL provide parameter STEP_DIV, default 12500000, clk cycles per step_tick period (4 Hz at 50 MHz); legal range 2 or more.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_next  input  1  raw asynchronous push-button, active-high, advances mode.
REQ-006 SHALL have port btn_pause  input  1  raw asynchronous push-button, active-high, toggles pause.
REQ-007 SHALL have port mode  output  2  pattern select for the downstream LED pattern stage (00 shift, 01 count, 10 Johnson).
REQ-008 SHALL have port step_tick  output  1  one-cycle enable pulse; downstream advances its pattern once per pulse.
REQ-009 SHALL have port mode_changed  output  1  one-cycle pulse in the first cycle a new mode value is visible; downstream uses it as a pattern restart.
REQ-010 SHALL have port paused  output  1  high while stepping is frozen.

Function
REQ-011 SHALL pass each raw button through a two-flop synchronizer before any other use.
REQ-012 SHALL debounce each synchronized button independently, with each button having its own counter.
REQ-013 SHALL update each button's debounced level only after the synchronized value differs from it for DB_CYCLES consecutive cycles.
REQ-014 SHALL clear a button's debounce counter in any cycle where the synchronized value equals its debounced level.
REQ-015 SHALL generate a one-cycle press event on each 0->1 transition of a debounced level; a held button produces exactly one event, and release produces none.
REQ-016 SHALL make the total latency from the first clk edge sampling raw btn_next high to the new mode value exactly 2 + DB_CYCLES + 1 cycles.
REQ-017 SHALL implement a mode FSM with states M_SHIFT (00), M_COUNT (01) and M_JOHNSON (10).
REQ-018 SHALL advance the mode FSM on each next-press event in the order 00 -> 01 -> 10 -> 00 (wrap).
REQ-019 SHALL never drive mode = 11; if the state register ever holds 11, it SHALL return to 00 on the next edge.
REQ-020 SHALL assert mode_changed for exactly one cycle, coincident with the first cycle of the new mode value.
REQ-021 SHALL run a step divider counter from 0 to STEP_DIV-1 that wraps to 0, and SHALL assert step_tick for one cycle when the counter equals STEP_DIV-1 and paused = 0.
REQ-022 SHALL toggle paused on each pause-press event.
REQ-023 SHALL, while paused = 1, hold the divider counter at its current value and force step_tick = 0.
REQ-024 SHALL, on resume, continue counting from the held value.
REQ-025 SHALL, on a mode advance, clear the divider counter to 0 and force step_tick = 0 in that cycle, so a mode change takes priority over a coincident tick.
REQ-026 SHALL apply both actions in the same cycle when a next-press event and a pause-press event coincide.
REQ-027 SHALL ignore any raw input pulse or glitch shorter than DB_CYCLES synchronized cycles.

Reset
REQ-028 SHALL, while reset = 1, force mode = 00, paused = 0, step_tick = 0 and mode_changed = 0.
REQ-029 SHALL, while reset = 1, clear all synchronizer flops, debounced levels, edge-detect registers, debounce counters and the divider counter to 0.
REQ-030 SHALL, after reset deassertion, emit the first step_tick STEP_DIV cycles later, provided no press occurs and paused = 0.
REQ-031 SHALL, on reset asserted mid-operation (any mode, paused or not, mid-debounce), return all state immediately to the values of REQ-028 and REQ-029 without waiting for a clock edge.

Verification (DB_CYCLES=4, STEP_DIV=5)
REQ-032 SHALL cover: no buttons for 30 cycles after reset -> mode = 00, step_tick pulses exactly every 5 cycles, mode_changed never asserted.
REQ-033 SHALL cover: btn_next high for 3 cycles, then low -> mode stays 00 and no mode_changed.
REQ-034 SHALL cover: btn_next held high for 40 cycles -> mode goes 00 -> 01 exactly once, 7 cycles after the first sampled high, with one mode_changed pulse and divider restarted (next tick 5 cycles later).
REQ-035 SHALL cover: three separated next presses -> mode sequence 01, 10, 00, with three mode_changed pulses and 11 never observed.
REQ-036 SHALL cover: pause press -> paused = 1 and no step_tick for 20 cycles; second pause press -> paused = 0 and ticks resume from the held count.
REQ-037 SHALL cover: in mode 10 with paused = 1, assert reset asynchronously between clk edges -> mode = 00 and paused = 0 immediately, with first tick 5 cycles after release.
